aes_spi_host_loader: RTL
========================

// Module: aes_spi_host_loader
// PURPOSE
//  Upstream front-end for the AES SPI master. Accepts 32-bit words on a valid/ready stream
//  and assembles a 128-bit data block plus an Nk*32-bit key. Starts one master transaction,
//  waits for its done flag, then returns the 128-bit result as four 32-bit words on a
//  valid/ready output stream. Sits between the host bus and the SPI master.
// PARAMETERS
//  Nk       4     key length in 32-bit words (4/6/8); key bus width = Nk*32
//  TIMEOUT  1024  max cycles in WAIT before abort; must exceed 256+Nk*32+8
// PORTS
//  clk          in   1        single clock (shared with SPI master)
//  rst_n        in   1        asynchronous, active-low reset
//  in_valid     in   1        input word valid
//  in_ready     out  1        loader can accept a word
//  in_word      in   32       data words first, then key words; MSW first
//  in_decrypt   in   1        mode, sampled with the first word: 0=encrypt, 1=decrypt
//  m_rst        out  1        active-high reset/start pulse to SPI master
//  m_sel_enc    out  1        master sel_encrypt (active-low chip select)
//  m_sel_dec    out  1        master sel_decrypt (active-low chip select)
//  m_data       out  128      block to master data_in
//  m_key        out  Nk*32    key to master key
//  m_done       in   1        master done_out (level; cleared by m_rst)
//  m_result     in   128      master data_out
//  out_valid    out  1        result word valid
//  out_ready    in   1        consumer accepts result word
//  out_word     out  32       result word, MSW first
//  busy         out  1        high in every state except COLLECT
//  err_timeout  out  1        one-cycle pulse when a transaction aborts on timeout
// BEHAVIOUR
//  Reset (rst_n=0, async): state=COLLECT, word cnt=0, m_data=0, m_key=0, m_rst=1,
//   m_sel_enc=1, m_sel_dec=1, in_ready=0, out_valid=0, out_word=0, busy=0, err_timeout=0.
//   First clk after release: in_ready=1, m_rst=0. Reset mid-transaction aborts it; no partial output.
//  FSM: COLLECT -> KICK -> WAIT -> DRAIN -> COLLECT; WAIT -> COLLECT on timeout.
//  COLLECT: in_ready=1. On each in_valid&&in_ready, store the word and advance cnt (0..3+Nk).
//   cnt 0..3 -> m_data[127-32*cnt -: 32]; cnt 4.. -> m_key[Nk*32-1-32*(cnt-4) -: 32].
//   At cnt==0, latch in_decrypt into mode reg. After word 3+Nk is accepted: in_ready=0, go to KICK.
//  KICK (exactly 1 cycle): m_rst=1. m_sel_enc=mode, m_sel_dec=~mode; both are already stable
//   this cycle because the master samples them during reset. Then go to WAIT. Zero the timer.
//  WAIT: m_rst=0. m_done ignored in the first WAIT cycle; it may be stale until the master's
//   reset takes effect. On m_done==1 (cycle>=2): capture m_result into out shift reg,
//   go to DRAIN. Timer increments each cycle; at TIMEOUT-1 without done: err_timeout=1 for
//   1 cycle, selects -> 1, go to COLLECT with cnt=0.
//  DRAIN: out_valid=1, out_word=outreg[127:96]. On out_ready: shift outreg left by 32 and
//   count. After the 4th handshake: out_valid=0, selects -> 1, go to COLLECT.
//   out_word/out_valid hold stable while out_ready=0.
//  m_data/m_key hold stable from KICK until next COLLECT write. They are not cleared after use.
//  Latency: last input handshake -> KICK next cycle; m_done seen -> out_valid next cycle.
//  in_ready=0 in KICK/WAIT/DRAIN; in_valid there is ignored (no backpressure loss).
//  Timer width = $clog2(TIMEOUT); word counter width = $clog2(4+Nk).
// STRUCTURE
//  Package aes_spi_pkg: state enum {COLLECT,KICK,WAIT,DRAIN}, BLOCK_W=128, WORD_W=32,
//   DEFAULT_TIMEOUT. Shared with the master-side code.
//  One sub-module, aes_word_unpacker: 128-bit load + 32-bit shift-out with 2-bit count and
//   last flag, used by DRAIN. The FSM and packing stay in the top module.
// TESTING (bench instantiates the real SPI master and slave)
//  1. Encrypt, FIPS-197 C.1: words 00112233,44556677,8899aabb,ccddeeff,00010203,04050607,
//     08090a0b,0c0d0e0f, decrypt=0 -> out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
//  2. Decrypt, same key, input 69c4e0d8.. -> 00112233,44556677,8899aabb,ccddeeff;
//     m_sel_dec=0 and m_sel_enc=1 during KICK.
//  3. Random in_valid gaps and out_ready stalls (50%) -> same words as case 1, none dropped
//     or duplicated, out_word stable while stalled.
//  4. Tie m_done=0, TIMEOUT=64 -> err_timeout pulses once 64 cycles after KICK; busy falls;
//     next 8 words are accepted normally.
//  5. Assert rst_n=0 during WAIT and during DRAIN after 2 words -> all outputs at reset values
//     asynchronously; next transaction returns correct case-1 result.
//  6. Nk=8 build, FIPS-197 C.3 key 00..1f, block 00112233.. -> 8ea2b7ca,516745bf,eafc4990,
//     4b496089.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI host-side loader and the master-side code.
package aes_spi_pkg;

  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    COLLECT,
    KICK,
    WAIT,
    DRAIN
  } loader_state_e;

endpackage

// File: rtl/aes_word_unpacker.sv
// Holds a 128-bit result and presents it as four 32-bit words, MSW first.
module aes_word_unpacker
  import aes_spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  output logic [WORD_W-1:0]  word,
  output logic               last
);

  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [1:0]         cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = 2'd0;
    end else if (shift) begin
      shreg_d = {shreg_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word = shreg_q[BLOCK_W-1 -: WORD_W];
  assign last = (cnt_q == 2'd3);

endmodule

// File: rtl/aes_spi_host_loader.sv
// Host-side front end for the AES SPI master: packs block+key from a word stream,
// runs one master transaction and streams the 128-bit result back out.
module aes_spi_host_loader
  import aes_spi_pkg::*;
#(
  parameter int Nk      = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_word,
  input  logic                 in_decrypt,
  output logic                 m_rst,
  output logic                 m_sel_enc,
  output logic                 m_sel_dec,
  output logic [BLOCK_W-1:0]   m_data,
  output logic [Nk*WORD_W-1:0] m_key,
  input  logic                 m_done,
  input  logic [BLOCK_W-1:0]   m_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_word,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int KEY_W = Nk * WORD_W;
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK + Nk);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1 + Nk);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  loader_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               mode_q, mode_d;
  logic [BLOCK_W-1:0] m_data_q, m_data_d;
  logic [KEY_W-1:0]   m_key_q, m_key_d;
  logic               m_rst_q, m_rst_d;
  logic               sel_enc_q, sel_enc_d;
  logic               sel_dec_q, sel_dec_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               res_load, res_shift, res_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    mode_d      = mode_q;
    m_data_d    = m_data_q;
    m_key_d     = m_key_q;
    m_rst_d     = m_rst_q;
    sel_enc_d   = sel_enc_q;
    sel_dec_d   = sel_dec_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    res_load    = 1'b0;
    res_shift   = 1'b0;

    case (state_q)
      COLLECT: begin
        in_ready_d = 1'b1;
        m_rst_d    = 1'b0;
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            if (cnt_q == CNT_W'(i)) m_data_d[BLOCK_W-1-WORD_W*i -: WORD_W] = in_word;
          end
          for (int i = 0; i < Nk; i++) begin
            if (cnt_q == CNT_W'(WORDS_PER_BLOCK + i)) m_key_d[KEY_W-1-WORD_W*i -: WORD_W] = in_word;
          end
          if (cnt_q == '0) mode_d = in_decrypt;
          if (cnt_q == LAST_CNT) begin
            // Selects go out together with the reset pulse; the master samples them while in reset.
            cnt_d      = '0;
            in_ready_d = 1'b0;
            m_rst_d    = 1'b1;
            sel_enc_d  = mode_q;
            sel_dec_d  = ~mode_q;
            timer_d    = '0;
            state_d    = KICK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      KICK: begin
        m_rst_d = 1'b0;
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // Done may still be left over from the previous run during the first WAIT cycle.
        if (m_done && (timer_q != '0)) begin
          res_load    = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DRAIN;
        end else if (timer_d == TMR_LAST) begin
          err_d      = 1'b1;
          sel_enc_d  = 1'b1;
          sel_dec_d  = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          state_d    = COLLECT;
        end
      end

      DRAIN: begin
        if (out_ready && out_valid_q) begin
          res_shift = 1'b1;
          if (res_last) begin
            out_valid_d = 1'b0;
            sel_enc_d   = 1'b1;
            sel_dec_d   = 1'b1;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            state_d     = COLLECT;
          end
        end
      end

      default: state_d = COLLECT;
    endcase

    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      timer_q     <= '0;
      mode_q      <= 1'b0;
      m_data_q    <= '0;
      m_key_q     <= '0;
      m_rst_q     <= 1'b1;
      sel_enc_q   <= 1'b1;
      sel_dec_q   <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      mode_q      <= mode_d;
      m_data_q    <= m_data_d;
      m_key_q     <= m_key_d;
      m_rst_q     <= m_rst_d;
      sel_enc_q   <= sel_enc_d;
      sel_dec_q   <= sel_dec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  aes_word_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (res_load),
    .load_data (m_result),
    .shift     (res_shift),
    .word      (out_word),
    .last      (res_last)
  );

  assign in_ready    = in_ready_q;
  assign m_rst       = m_rst_q;
  assign m_sel_enc   = sel_enc_q;
  assign m_sel_dec   = sel_dec_q;
  assign m_data      = m_data_q;
  assign m_key       = m_key_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
